// File: rtl/sha_multi_pkg.sv
// Shared types and constants for the multi-core SHA-256 stage: lane states, IV, widths.
// No logic of its own; latency and backpressure are defined by the importing modules.
package sha_multi_pkg;

  localparam int BLOCK_W = 512;
  localparam int H_W     = 256;

  localparam logic [H_W-1:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_LOAD  = 3'd1,
    L_ARM   = 3'd2,
    L_RUN   = 3'd3,
    L_NWAIT = 3'd4,
    L_DONE  = 3'd5
  } lane_state_t;

  typedef struct packed {
    logic               last;
    logic [BLOCK_W-1:0] data;
  } text_ent_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_core_pipelined.sv
// SHA-256 block engine, one round per cycle; init/next to ready is 66 cycles per block.
// Backpressure: init/next are only honoured while ready; digest holds until the next init/next.
module sha256_core_pipelined
  import sha_multi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               next,
  input  logic               first,
  input  logic [BLOCK_W-1:0] block,
  input  logic [H_W-1:0]     digest_in,
  output logic               ready,
  output logic [H_W-1:0]     digest
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {C_IDLE, C_ROUND, C_FINAL} core_state_t;

  core_state_t    state, state_nxt;
  logic [5:0]     rnd;
  logic [31:0]    w [16];
  logic [31:0]    v [8];
  logic [31:0]    h [8];
  logic [31:0]    t1, t2, w_new;
  logic [H_W-1:0] h_init;

  assign h_init = first ? SHA256_IV : digest_in;
  assign ready  = (state == C_IDLE);
  assign digest = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};

  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
       + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    // Sliding 16-word schedule window: w[0] is W[t], w_new is W[t+16].
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= C_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:  if (init || next) state_nxt = C_ROUND;
      C_ROUND: if (rnd == 6'd63) state_nxt = C_FINAL;
      C_FINAL: state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v[i] <= '0;
        h[i] <= '0;
      end
    end else if (state == C_IDLE && (init || next)) begin
      rnd <= '0;
      for (int i = 0; i < 16; i++) w[i] <= block[BLOCK_W-1-32*i -: 32];
      for (int i = 0; i < 8; i++) begin
        if (init) begin
          h[i] <= h_init[H_W-1-32*i -: 32];
          v[i] <= h_init[H_W-1-32*i -: 32];
        end else begin
          v[i] <= h[i];
        end
      end
    end else if (state == C_ROUND) begin
      rnd  <= rnd + 6'd1;
      v[0] <= t1 + t2;
      v[1] <= v[0];
      v[2] <= v[1];
      v[3] <= v[2];
      v[4] <= v[3] + t1;
      v[5] <= v[4];
      v[6] <= v[5];
      v[7] <= v[6];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end else if (state == C_FINAL) begin
      for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
    end
  end

endmodule

// File: rtl/sha_multi_fifo.sv
// Generic show-ahead FIFO; pop_data is the head entry combinationally, zero added latency.
// Backpressure: full blocks push, empty blocks pop; both are ignored rather than corrupting state.
module sha_multi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sha_multi_lane.sv
// One hashing lane: block capture, per-message block count, core sequencing; ~69 cycles per block.
// Backpressure: accepts a dispatch only in L_IDLE/L_NWAIT; holds the digest in L_DONE until retired.
module sha_multi_lane
  import sha_multi_pkg::*;
#(
  parameter int MAX_BLOCKS = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               first,
  input  logic               dispatch,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_last,
  input  logic [H_W-1:0]     hin_data,
  input  logic               retire,
  output logic [2:0]         lane_st,
  output logic [H_W-1:0]     digest,
  output logic               err
);
  localparam int CW = $clog2(MAX_BLOCKS + 1);

  lane_state_t        state, state_nxt;
  logic [BLOCK_W-1:0] blk_q;
  logic [H_W-1:0]     hin_q;
  logic               last_q;
  logic               first_blk;
  logic [CW-1:0]      blk_cnt;
  logic               core_rdy;
  logic               accept;

  assign lane_st = state;
  assign accept  = dispatch && (state == L_IDLE || state == L_NWAIT);
  assign err     = dispatch && (state == L_NWAIT) && (blk_cnt == CW'(MAX_BLOCKS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= L_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      L_IDLE:  if (dispatch) state_nxt = L_LOAD;
      L_LOAD:  state_nxt = L_ARM;
      L_ARM:   state_nxt = L_RUN;
      L_RUN:   if (core_rdy) state_nxt = last_q ? L_DONE : L_NWAIT;
      L_NWAIT: if (dispatch) state_nxt = L_LOAD;
      L_DONE:  if (retire) state_nxt = L_IDLE;
      default: state_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q     <= '0;
      hin_q     <= '0;
      last_q    <= 1'b0;
      first_blk <= 1'b0;
      blk_cnt   <= '0;
    end else if (accept) begin
      blk_q     <= blk_data;
      last_q    <= blk_last;
      first_blk <= (state == L_IDLE);
      if (state == L_IDLE) begin
        hin_q   <= first ? '0 : hin_data;
        blk_cnt <= CW'(1);
      end else if (blk_cnt != CW'(MAX_BLOCKS)) begin
        blk_cnt <= blk_cnt + CW'(1);
      end
    end
  end

  sha256_core_pipelined u_core (
    .clk       (clk),
    .reset     (reset),
    .init      ((state == L_LOAD) && first_blk),
    .next      ((state == L_LOAD) && !first_blk),
    .first     (first),
    .block     (blk_q),
    .digest_in (hin_q),
    .ready     (core_rdy),
    .digest    (digest)
  );

endmodule

// File: rtl/sha_multi_module.sv
// NUM_CORES SHA-256 lanes fed round-robin from text/Hin FIFOs; digests retire in message order.
// Latency ~70 cycles per block; rdy drops when a FIFO fills; digests wait for hout_rdy. SHA_MULTI_PERF_CNT_EN adds perf counters.
module sha_multi_module
  import sha_multi_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BLOCKS = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               first,
  input  logic               text_vld,
  output logic               text_rdy,
  input  logic [BLOCK_W-1:0] text_data,
  input  logic               text_last,
  input  logic               hin_vld,
  output logic               hin_rdy,
  input  logic [H_W-1:0]     hin_data,
  output logic               hout_vld,
  input  logic               hout_rdy,
  output logic [H_W-1:0]     hout_data,
  output logic               busy,
  output logic               err_len
`ifdef SHA_MULTI_PERF_CNT_EN
  ,
  output logic [31:0]        perf_msg_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);
  localparam int PW = ptr_w(NUM_CORES);

  text_ent_t        t_in, t_head;
  logic             t_full, t_empty, h_full, h_empty;
  logic [H_W-1:0]   h_head;
  logic             disp_go, pop_hin, lanes_active, hout_fire;
  logic [PW-1:0]    disp_ptr, ret_ptr;
  logic [2:0]       lane_st  [NUM_CORES];
  logic [H_W-1:0]   lane_dig [NUM_CORES];
  logic [NUM_CORES-1:0] lane_disp, lane_ret, lane_err;

  assign t_in     = '{last: text_last, data: text_data};
  assign text_rdy = !t_full && !reset;
  assign hin_rdy  = !h_full && !reset;

  sha_multi_fifo #(.W($bits(text_ent_t)), .DEPTH(FIFO_DEPTH)) u_text_fifo (
    .clk(clk), .reset(reset), .push(text_vld && text_rdy), .push_data(t_in),
    .pop(disp_go), .pop_data(t_head), .full(t_full), .empty(t_empty)
  );

  sha_multi_fifo #(.W(H_W), .DEPTH(FIFO_DEPTH)) u_hin_fifo (
    .clk(clk), .reset(reset), .push(hin_vld && hin_rdy), .push_data(hin_data),
    .pop(pop_hin), .pop_data(h_head), .full(h_full), .empty(h_empty)
  );

  // A first block needs a free lane plus a chaining value; continuation blocks reuse the lane's H.
  always_comb begin
    disp_go = 1'b0;
    pop_hin = 1'b0;
    if (!t_empty) begin
      if (lane_st[disp_ptr] == L_IDLE && (first || !h_empty)) begin
        disp_go = 1'b1;
        pop_hin = !first;
      end else if (lane_st[disp_ptr] == L_NWAIT) begin
        disp_go = 1'b1;
      end
    end
  end

  assign hout_vld  = (lane_st[ret_ptr] == L_DONE);
  assign hout_data = hout_vld ? lane_dig[ret_ptr] : '0;
  assign hout_fire = hout_vld && hout_rdy;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    assign lane_disp[i] = disp_go && (disp_ptr == PW'(i));
    assign lane_ret[i]  = hout_fire && (ret_ptr == PW'(i));

    sha_multi_lane #(.MAX_BLOCKS(MAX_BLOCKS)) u_lane (
      .clk(clk), .reset(reset), .first(first), .dispatch(lane_disp[i]),
      .blk_data(t_head.data), .blk_last(t_head.last), .hin_data(h_head),
      .retire(lane_ret[i]), .lane_st(lane_st[i]), .digest(lane_dig[i]), .err(lane_err[i])
    );
  end

  always_comb begin
    lanes_active = 1'b0;
    for (int i = 0; i < NUM_CORES; i++)
      if (lane_st[i] != L_IDLE) lanes_active = 1'b1;
  end

  assign busy = lanes_active || !t_empty || !h_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_ptr <= '0;
      ret_ptr  <= '0;
      err_len  <= 1'b0;
    end else begin
      if (disp_go && t_head.last)
        disp_ptr <= (disp_ptr == PW'(NUM_CORES-1)) ? '0 : disp_ptr + PW'(1);
      if (hout_fire)
        ret_ptr <= (ret_ptr == PW'(NUM_CORES-1)) ? '0 : ret_ptr + PW'(1);
      if (|lane_err)
        err_len <= 1'b1;
    end
  end

`ifdef SHA_MULTI_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_msg_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hout_fire)
        perf_msg_cnt <= perf_msg_cnt + 32'd1;
      if (!t_empty && !disp_go)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_multi_module.sv
// Directed bench for sha_multi_module with known SHA-256 vectors ("abc", "", "a", NIST 2-block).
module tb_sha_multi_module;
  import sha_multi_pkg::*;

  logic           clk = 1'b0;
  logic           reset, first, text_vld, text_last, hin_vld, hout_rdy;
  logic           text_rdy, hin_rdy, hout_vld, busy, err_len;
  logic [511:0]   text_data;
  logic [255:0]   hin_data, hout_data;
`ifdef SHA_MULTI_PERF_CNT_EN
  logic [31:0]    perf_msg_cnt, perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_A     = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] D_2B    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] M_A     = {32'h61800000, 448'h0, 32'h00000008};
  localparam logic [511:0] M_2B1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M_2B2   = {480'h0, 32'h000001c0};

  sha_multi_module dut (
    .clk       (clk),
    .reset     (reset),
    .first     (first),
    .text_vld  (text_vld),
    .text_rdy  (text_rdy),
    .text_data (text_data),
    .text_last (text_last),
    .hin_vld   (hin_vld),
    .hin_rdy   (hin_rdy),
    .hin_data  (hin_data),
    .hout_vld  (hout_vld),
    .hout_rdy  (hout_rdy),
    .hout_data (hout_data),
    .busy      (busy),
    .err_len   (err_len)
`ifdef SHA_MULTI_PERF_CNT_EN
    ,
    .perf_msg_cnt   (perf_msg_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_blk(input logic [511:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    text_data = d;
    text_last = l;
    text_vld  = 1'b1;
    while (!text_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!text_rdy) check("text_rdy_timeout", 256'(text_rdy), 256'd1);
    @(posedge clk);
    #1 text_vld = 1'b0;
  endtask

  task automatic send_hin(input logic [255:0] h);
    int n = 0;
    @(negedge clk);
    hin_data = h;
    hin_vld  = 1'b1;
    while (!hin_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!hin_rdy) check("hin_rdy_timeout", 256'(hin_rdy), 256'd1);
    @(posedge clk);
    #1 hin_vld = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [255:0] exp);
    int n = 0;
    @(negedge clk);
    hout_rdy = 1'b1;
    while (!hout_vld && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!hout_vld) check({tag, "_timeout"}, 256'(hout_vld), 256'd1);
    else           check(tag, hout_data, exp);
    @(posedge clk);
    #1 hout_rdy = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; first = 1'b1; text_vld = 1'b0; text_last = 1'b0; text_data = '0;
    hin_vld = 1'b0; hin_data = '0; hout_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hout_vld", 256'(hout_vld), 256'd0);
    check("rst_hout_data", hout_data, 256'd0);
    check("rst_text_rdy", 256'(text_rdy), 256'd0);
    check("rst_hin_rdy", 256'(hin_rdy), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_err_len", 256'(err_len), 256'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_text_rdy", 256'(text_rdy), 256'd1);

    // Single-block "abc" with IV.
    send_blk(M_ABC, 1'b1);
    get_out("abc_first1", D_ABC);

    // Two-block NIST message lands entirely on lane 0.
    do_reset();
    send_blk(M_2B1, 1'b0);
    send_blk(M_2B2, 1'b1);
    get_out("two_block", D_2B);
    check("disp_ptr_after_2blk", 256'(dut.disp_ptr), 256'd1);

    // Six messages with the output stalled; all four lanes fill, order must be kept.
    do_reset();
    send_blk(M_ABC, 1'b1);
    send_blk(M_EMPTY, 1'b1);
    send_blk(M_A, 1'b1);
    send_blk(M_EMPTY, 1'b1);
    send_blk(M_ABC, 1'b1);
    send_blk(M_A, 1'b1);
    repeat (300) @(negedge clk);
    check("stall_text_rdy", 256'(text_rdy), 256'd1);
    check("stall_hout_vld", 256'(hout_vld), 256'd1);
    check("stall_busy", 256'(busy), 256'd1);
    get_out("ord0", D_ABC);
    get_out("ord1", D_EMPTY);
    get_out("ord2", D_A);
    get_out("ord3", D_EMPTY);
    get_out("ord4", D_ABC);
    get_out("ord5", D_A);

    // first=0: dispatch waits for Hin; IV as Hin must match the first=1 result.
    @(negedge clk);
    first = 1'b0;
    do_reset();
    send_blk(M_ABC, 1'b1);
    repeat (50) @(negedge clk);
    check("nohin_busy", 256'(busy), 256'd1);
    check("nohin_hout_vld", 256'(hout_vld), 256'd0);
`ifdef SHA_MULTI_PERF_CNT_EN
    check("perf_stall_nonzero", 256'(perf_stall_cnt >= 32'd50), 256'd1);
`endif
    send_hin(IV);
    get_out("abc_first0", D_ABC);
    // A two-block message consumes exactly one Hin.
    send_hin(IV);
    send_blk(M_2B1, 1'b0);
    send_blk(M_2B2, 1'b1);
    get_out("two_block_first0", D_2B);
    repeat (5) @(negedge clk);
    check("first0_idle_busy", 256'(busy), 256'd0);
`ifdef SHA_MULTI_PERF_CNT_EN
    check("perf_msg_cnt", 256'(perf_msg_cnt), 256'd2);
`endif

    // Reset with three lanes mid-hash drops everything.
    @(negedge clk);
    first = 1'b1;
    do_reset();
    send_blk(M_ABC, 1'b1);
    send_blk(M_A, 1'b1);
    send_blk(M_EMPTY, 1'b1);
    repeat (20) @(negedge clk);
    check("midrun_busy_before", 256'(busy), 256'd1);
    reset = 1'b1;
    #1;
    check("midrun_rst_hout_vld", 256'(hout_vld), 256'd0);
    check("midrun_rst_busy", 256'(busy), 256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_blk(M_ABC, 1'b1);
    get_out("abc_after_rst", D_ABC);
    check("disp_ptr_after_rst", 256'(dut.disp_ptr), 256'd1);
`ifdef SHA_MULTI_PERF_CNT_EN
    check("perf_msg_after_rst", 256'(perf_msg_cnt), 256'd1);
`endif
    check("err_len_final", 256'(err_len), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
